// File: rtl/id_pkg.sv
// Shared definitions for the decode stage: register-index sizing, bubble
// control codes and the grouped control word carried by the ID/EX register.
package id_pkg;

  function automatic int ridx_of(input int nreg);
    return (nreg > 1) ? $clog2(nreg) : 1;
  endfunction

  localparam logic [4:0] ALUOP_NOP = 5'd0;
  localparam logic [2:0] NPCOP_PC4 = 3'd0;
  localparam logic [1:0] WDSEL_ALU = 2'd0;

  typedef struct packed {
    logic       RegWrite;
    logic [4:0] ALUOp;
    logic [2:0] NPCOp;
    logic       ALUSrc;
    logic       mem_w;
    logic [3:0] wea;
    logic [1:0] WDSel;
  } id_ctrl_t;

  // A bubble must never write a register, touch memory or redirect the PC.
  localparam id_ctrl_t CTRL_BUBBLE = '{
    RegWrite: 1'b0,
    ALUOp:    ALUOP_NOP,
    NPCOp:    NPCOP_PC4,
    ALUSrc:   1'b0,
    mem_w:    1'b0,
    wea:      4'b0000,
    WDSel:    WDSEL_ALU
  };

endpackage

// File: rtl/EXT.sv
// Immediate generator: builds the 32-bit immediate for the format selected
// by the one-hot EXTOp; unknown formats yield zero.
module EXT (
  input  logic [4:0]  iimm_shamt,
  input  logic [11:0] iimm,
  input  logic [11:0] simm,
  input  logic [11:0] bimm,
  input  logic [19:0] uimm,
  input  logic [19:0] jimm,
  input  logic [5:0]  EXTOp,
  output logic [31:0] immout
);

  always_comb begin
    immout = 32'd0;
    case (EXTOp)
      6'b100000: immout = {27'd0, iimm_shamt};
      6'b010000: immout = {{20{iimm[11]}}, iimm};
      6'b001000: immout = {{20{simm[11]}}, simm};
      6'b000100: immout = {{19{bimm[11]}}, bimm, 1'b0};
      6'b000010: immout = {uimm, 12'd0};
      6'b000001: immout = {{11{jimm[19]}}, jimm, 1'b0};
      default:   immout = 32'd0;
    endcase
  end

endmodule

// File: rtl/ctrl.sv
// RV32I main control decoder: opcode/funct fields to datapath control and
// the one-hot immediate format select used by EXT.
module ctrl (
  input  logic [6:0] Op,
  input  logic [6:0] Funct7,
  input  logic [2:0] Funct3,
  output logic       RegWrite,
  output logic [4:0] ALUOp,
  output logic [2:0] NPCOp,
  output logic       ALUSrc,
  output logic       mem_w,
  output logic [3:0] wea,
  output logic [1:0] WDSel,
  output logic [5:0] EXTOp
);

  localparam logic [4:0] A_NOP = 5'd0,  A_LUI = 5'd1,  A_AUIPC = 5'd2, A_ADD = 5'd3;
  localparam logic [4:0] A_SUB = 5'd4,  A_BNE = 5'd5,  A_BLT = 5'd6,   A_BGE = 5'd7;
  localparam logic [4:0] A_BLTU = 5'd8, A_BGEU = 5'd9, A_SLT = 5'd10,  A_SLTU = 5'd11;
  localparam logic [4:0] A_XOR = 5'd12, A_OR = 5'd13,  A_AND = 5'd14,  A_SLL = 5'd15;
  localparam logic [4:0] A_SRL = 5'd16, A_SRA = 5'd17, A_BEQ = 5'd18;

  localparam logic [5:0] E_SHAMT = 6'b100000, E_I = 6'b010000, E_S = 6'b001000;
  localparam logic [5:0] E_B = 6'b000100, E_U = 6'b000010, E_J = 6'b000001;

  logic alt;
  assign alt = (Funct7 == 7'b0100000);

  always_comb begin
    RegWrite = 1'b0;
    ALUOp    = A_NOP;
    NPCOp    = 3'd0;
    ALUSrc   = 1'b0;
    mem_w    = 1'b0;
    wea      = 4'b0000;
    WDSel    = 2'd0;
    EXTOp    = 6'b000000;
    case (Op)
      7'b0110011: begin
        RegWrite = 1'b1;
        case (Funct3)
          3'b000:  ALUOp = alt ? A_SUB : A_ADD;
          3'b001:  ALUOp = A_SLL;
          3'b010:  ALUOp = A_SLT;
          3'b011:  ALUOp = A_SLTU;
          3'b100:  ALUOp = A_XOR;
          3'b101:  ALUOp = alt ? A_SRA : A_SRL;
          3'b110:  ALUOp = A_OR;
          default: ALUOp = A_AND;
        endcase
      end
      7'b0010011: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        EXTOp    = E_I;
        case (Funct3)
          3'b000:  ALUOp = A_ADD;
          3'b010:  ALUOp = A_SLT;
          3'b011:  ALUOp = A_SLTU;
          3'b100:  ALUOp = A_XOR;
          3'b110:  ALUOp = A_OR;
          3'b111:  ALUOp = A_AND;
          3'b001: begin
            ALUOp = A_SLL;
            EXTOp = E_SHAMT;
          end
          default: begin
            ALUOp = alt ? A_SRA : A_SRL;
            EXTOp = E_SHAMT;
          end
        endcase
      end
      7'b0000011: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        WDSel    = 2'd1;
        ALUOp    = A_ADD;
        EXTOp    = E_I;
      end
      7'b0100011: begin
        mem_w  = 1'b1;
        ALUSrc = 1'b1;
        ALUOp  = A_ADD;
        EXTOp  = E_S;
        case (Funct3)
          3'b000:  wea = 4'b0001;
          3'b001:  wea = 4'b0011;
          3'b010:  wea = 4'b1111;
          default: wea = 4'b0000;
        endcase
      end
      7'b1100011: begin
        NPCOp = 3'd1;
        EXTOp = E_B;
        case (Funct3)
          3'b000:  ALUOp = A_BEQ;
          3'b001:  ALUOp = A_BNE;
          3'b100:  ALUOp = A_BLT;
          3'b101:  ALUOp = A_BGE;
          3'b110:  ALUOp = A_BLTU;
          3'b111:  ALUOp = A_BGEU;
          default: ALUOp = A_NOP;
        endcase
      end
      7'b1101111: begin
        RegWrite = 1'b1;
        NPCOp    = 3'd2;
        WDSel    = 2'd2;
        ALUOp    = A_ADD;
        EXTOp    = E_J;
      end
      7'b1100111: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        NPCOp    = 3'd3;
        WDSel    = 2'd2;
        ALUOp    = A_ADD;
        EXTOp    = E_I;
      end
      7'b0110111: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUOp    = A_LUI;
        EXTOp    = E_U;
      end
      7'b0010111: begin
        RegWrite = 1'b1;
        ALUSrc   = 1'b1;
        ALUOp    = A_AUIPC;
        EXTOp    = E_U;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rf_bypass.sv
// Register file with two read ports, one write port, hard-wired zero
// register and write-first bypass so a WB write is visible in the same cycle.
module rf_bypass
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RIDX = ridx_of(NREG)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            we,
  input  logic [RIDX-1:0] waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [RIDX-1:0] raddr1,
  input  logic [RIDX-1:0] raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic            wr_en;

  assign wr_en = we && (waddr != '0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Register 0 is checked before the bypass so a stray write to x0 never leaks.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (wr_en && waddr == raddr1) ? wdata : regs_q[raddr1];
    if (raddr2 != '0) rdata2 = (wr_en && waddr == raddr2) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/id_stage_pipe.sv
// Decode stage with its own ID/EX register: decodes, reads operands with WB
// bypass, stalls IF on a load-use hazard and bubbles on stall or flush.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int RIDX = ridx_of(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            if_valid,
  input  logic            flush,
  input  logic            ex_MemRead,
  input  logic [RIDX-1:0] ex_rd,
  input  logic            RegWrite_in,
  input  logic [RIDX-1:0] wregnum,
  input  logic [XLEN-1:0] WD,
  output logic            stall_out,
  output logic            id_valid_out,
  output logic            RegWrite_out,
  output logic [4:0]      ALUOp_out,
  output logic [2:0]      NPCOp_out,
  output logic            ALUSrc_out,
  output logic            mem_w_out,
  output logic [3:0]      wea_out,
  output logic [1:0]      WDSel_out,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  output logic [RIDX-1:0] rs1num_out,
  output logic [RIDX-1:0] rs2num_out,
  output logic [RIDX-1:0] wregnum_out,
  output logic [XLEN-1:0] ImmGen_out,
  output logic [XLEN-1:0] pc_out
);

  logic [RIDX-1:0] rs1_idx, rs2_idx, rd_idx;
  logic [XLEN-1:0] rs1_val, rs2_val, imm_x;
  logic [31:0]     ext_imm;
  logic [5:0]      ext_op;
  logic            c_regwrite, c_alusrc, c_mem_w;
  logic [4:0]      c_aluop;
  logic [2:0]      c_npcop;
  logic [3:0]      c_wea;
  logic [1:0]      c_wdsel;
  id_ctrl_t        dec_ctrl;
  logic            hz, load_en;

  id_ctrl_t        ctrl_d, ctrl_q;
  logic            valid_d, valid_q;
  logic [XLEN-1:0] rs1_d, rs1_q, rs2_d, rs2_q, imm_d, imm_q, pc_d, pc_q;
  logic [RIDX-1:0] rs1num_d, rs1num_q, rs2num_d, rs2num_q, rd_d, rd_q;

  assign rs1_idx = RIDX'(instr_in[19:15]);
  assign rs2_idx = RIDX'(instr_in[24:20]);
  assign rd_idx  = RIDX'(instr_in[11:7]);

  ctrl u_ctrl (
    .Op       (instr_in[6:0]),
    .Funct7   (instr_in[31:25]),
    .Funct3   (instr_in[14:12]),
    .RegWrite (c_regwrite),
    .ALUOp    (c_aluop),
    .NPCOp    (c_npcop),
    .ALUSrc   (c_alusrc),
    .mem_w    (c_mem_w),
    .wea      (c_wea),
    .WDSel    (c_wdsel),
    .EXTOp    (ext_op)
  );

  EXT u_ext (
    .iimm_shamt (instr_in[24:20]),
    .iimm       (instr_in[31:20]),
    .simm       ({instr_in[31:25], instr_in[11:7]}),
    .bimm       ({instr_in[31], instr_in[7], instr_in[30:25], instr_in[11:8]}),
    .uimm       (instr_in[31:12]),
    .jimm       ({instr_in[31], instr_in[19:12], instr_in[20], instr_in[30:21]}),
    .EXTOp      (ext_op),
    .immout     (ext_imm)
  );

  assign dec_ctrl = {c_regwrite, c_aluop, c_npcop, c_alusrc, c_mem_w, c_wea, c_wdsel};

  // EXT always produces 32 bits; narrower datapaths keep the LSBs, wider ones sign-extend.
  generate
    if (XLEN <= 32) begin : g_imm_trunc
      assign imm_x = ext_imm[XLEN-1:0];
    end else begin : g_imm_sext
      assign imm_x = {{(XLEN-32){ext_imm[31]}}, ext_imm};
    end
  endgenerate

  rf_bypass #(
    .XLEN (XLEN),
    .NREG (NREG),
    .RIDX (RIDX)
  ) u_rf (
    .clk    (clk),
    .rst_n  (rst),
    .we     (RegWrite_in),
    .waddr  (wregnum),
    .wdata  (WD),
    .raddr1 (rs1_idx),
    .raddr2 (rs2_idx),
    .rdata1 (rs1_val),
    .rdata2 (rs2_val)
  );

  // One bubble per load suffices: next cycle the load result is forwardable.
  assign hz        = if_valid & ex_MemRead & (ex_rd != '0) &
                     ((ex_rd == rs1_idx) | (ex_rd == rs2_idx));
  assign stall_out = hz & ~flush;
  assign load_en   = if_valid & ~flush & ~hz;

  always_comb begin
    valid_d  = 1'b0;
    ctrl_d   = CTRL_BUBBLE;
    rs1_d    = '0;
    rs2_d    = '0;
    rs1num_d = '0;
    rs2num_d = '0;
    rd_d     = '0;
    imm_d    = '0;
    pc_d     = '0;
    if (load_en) begin
      valid_d  = 1'b1;
      ctrl_d   = dec_ctrl;
      rs1_d    = rs1_val;
      rs2_d    = rs2_val;
      rs1num_d = rs1_idx;
      rs2num_d = rs2_idx;
      rd_d     = rd_idx;
      imm_d    = imm_x;
      pc_d     = pc_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q  <= 1'b0;
      ctrl_q   <= CTRL_BUBBLE;
      rs1_q    <= '0;
      rs2_q    <= '0;
      rs1num_q <= '0;
      rs2num_q <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      rs1num_q <= rs1num_d;
      rs2num_q <= rs2num_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
    end
  end

  assign id_valid_out = valid_q;
  assign RegWrite_out = ctrl_q.RegWrite;
  assign ALUOp_out    = ctrl_q.ALUOp;
  assign NPCOp_out    = ctrl_q.NPCOp;
  assign ALUSrc_out   = ctrl_q.ALUSrc;
  assign mem_w_out    = ctrl_q.mem_w;
  assign wea_out      = ctrl_q.wea;
  assign WDSel_out    = ctrl_q.WDSel;
  assign rs1_out      = rs1_q;
  assign rs2_out      = rs2_q;
  assign rs1num_out   = rs1num_q;
  assign rs2num_out   = rs2num_q;
  assign wregnum_out  = rd_q;
  assign ImmGen_out   = imm_q;
  assign pc_out       = pc_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios plus randomized
// traffic compared against a behavioural model of decode, hazards and regfile.
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int RIDX = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic [31:0]     instr_in;
  logic [XLEN-1:0] pc_in;
  logic            if_valid, flush, ex_MemRead, RegWrite_in;
  logic [RIDX-1:0] ex_rd, wregnum;
  logic [XLEN-1:0] WD;
  logic            stall_out, id_valid_out, RegWrite_out, ALUSrc_out, mem_w_out;
  logic [4:0]      ALUOp_out;
  logic [2:0]      NPCOp_out;
  logic [3:0]      wea_out;
  logic [1:0]      WDSel_out;
  logic [XLEN-1:0] rs1_out, rs2_out, ImmGen_out, pc_out;
  logic [RIDX-1:0] rs1num_out, rs2num_out, wregnum_out;

  int n_assert;
  int n_fail;
  logic [31:0] mregs [NREG];

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .if_valid(if_valid),
    .flush(flush), .ex_MemRead(ex_MemRead), .ex_rd(ex_rd), .RegWrite_in(RegWrite_in),
    .wregnum(wregnum), .WD(WD), .stall_out(stall_out), .id_valid_out(id_valid_out),
    .RegWrite_out(RegWrite_out), .ALUOp_out(ALUOp_out), .NPCOp_out(NPCOp_out),
    .ALUSrc_out(ALUSrc_out), .mem_w_out(mem_w_out), .wea_out(wea_out),
    .WDSel_out(WDSel_out), .rs1_out(rs1_out), .rs2_out(rs2_out),
    .rs1num_out(rs1num_out), .rs2num_out(rs2num_out), .wregnum_out(wregnum_out),
    .ImmGen_out(ImmGen_out), .pc_out(pc_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic fl, input logic mr,
                                input logic [4:0] exrd, input logic rw, input logic [4:0] wn,
                                input logic [31:0] wd, input logic [31:0] ins, input logic [31:0] pc);
    if_valid = iv; flush = fl; ex_MemRead = mr; ex_rd = exrd;
    RegWrite_in = rw; wregnum = wn; WD = wd; instr_in = ins; pc_in = pc;
  endtask

  function automatic logic [31:0] mread(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (RegWrite_in && wregnum == r) return WD;
    return mregs[r];
  endfunction

  task automatic check_zero_outputs(input string tag);
    chk({tag, ":valid"}, id_valid_out, 0);
    chk({tag, ":regwrite"}, RegWrite_out, 0);
    chk({tag, ":aluop"}, ALUOp_out, 0);
    chk({tag, ":memw"}, mem_w_out, 0);
    chk({tag, ":wea"}, wea_out, 0);
    chk({tag, ":rs1"}, rs1_out, 0);
    chk({tag, ":rs2"}, rs2_out, 0);
    chk({tag, ":imm"}, ImmGen_out, 0);
    chk({tag, ":pc"}, pc_out, 0);
    chk({tag, ":rd"}, wregnum_out, 0);
  endtask

  // Model one decode cycle: predict stall now, then compare the registered outputs after the edge.
  task automatic step(input string tag);
    logic [4:0]  s1, s2, rd;
    logic        hz, ld, e_rw, e_src, e_mw;
    logic [3:0]  e_wea;
    logic [1:0]  e_wdsel;
    logic [31:0] e_rs1, e_rs2, e_imm, e_pc;
    #1;
    s1 = instr_in[19:15];
    s2 = instr_in[24:20];
    rd = instr_in[11:7];
    hz = if_valid && ex_MemRead && (ex_rd != 0) && (ex_rd == s1 || ex_rd == s2);
    ld = if_valid && !flush && !hz;
    e_rs1 = mread(s1);
    e_rs2 = mread(s2);
    e_pc  = pc_in;
    e_rw = 0; e_src = 0; e_mw = 0; e_wea = 0; e_wdsel = 0; e_imm = 0;
    case (instr_in[6:0])
      7'b0110011: e_rw = 1;
      7'b0010011: begin e_rw = 1; e_src = 1; e_imm = {{20{instr_in[31]}}, instr_in[31:20]}; end
      7'b0000011: begin e_rw = 1; e_src = 1; e_wdsel = 1; e_imm = {{20{instr_in[31]}}, instr_in[31:20]}; end
      7'b0100011: begin
        e_src = 1; e_mw = 1; e_wea = 4'b1111;
        e_imm = {{20{instr_in[31]}}, instr_in[31:25], instr_in[11:7]};
      end
      default: ;
    endcase
    chk({tag, ":stall"}, stall_out, hz && !flush);
    if (RegWrite_in && wregnum != 0) mregs[wregnum] = WD;
    @(posedge clk);
    #1;
    chk({tag, ":valid"}, id_valid_out, ld);
    chk({tag, ":regwrite"}, RegWrite_out, ld ? e_rw : 1'b0);
    chk({tag, ":alusrc"}, ALUSrc_out, ld ? e_src : 1'b0);
    chk({tag, ":memw"}, mem_w_out, ld ? e_mw : 1'b0);
    chk({tag, ":wea"}, wea_out, ld ? e_wea : 4'b0);
    chk({tag, ":wdsel"}, WDSel_out, ld ? e_wdsel : 2'b0);
    chk({tag, ":npcop"}, NPCOp_out, 0);
    if (ld) chk({tag, ":aluop_set"}, ALUOp_out != 0, 1);
    else    chk({tag, ":aluop"}, ALUOp_out, 0);
    chk({tag, ":rs1"}, rs1_out, ld ? e_rs1 : 32'd0);
    chk({tag, ":rs2"}, rs2_out, ld ? e_rs2 : 32'd0);
    chk({tag, ":rs1num"}, rs1num_out, ld ? s1 : 5'd0);
    chk({tag, ":rs2num"}, rs2num_out, ld ? s2 : 5'd0);
    chk({tag, ":rd"}, wregnum_out, ld ? rd : 5'd0);
    chk({tag, ":imm"}, ImmGen_out, ld ? e_imm : 32'd0);
    chk({tag, ":pc"}, pc_out, ld ? e_pc : 32'd0);
  endtask

  initial begin
    logic [31:0] ins;
    logic [11:0] imm12;
    logic [4:0]  r_d, r_s1, r_s2;
    n_assert = 0;
    n_fail   = 0;
    foreach (mregs[i]) mregs[i] = 32'd0;

    rst = 1'b0;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 32'h00700293, 32'h100);
    #2;
    check_zero_outputs("reset");
    #10;
    rst = 1'b1;

    step("addi");
    chk("addi:valid_k", id_valid_out, 1);
    chk("addi:regwrite_k", RegWrite_out, 1);
    chk("addi:alusrc_k", ALUSrc_out, 1);
    chk("addi:imm_k", ImmGen_out, 7);
    chk("addi:rd_k", wregnum_out, 5);
    chk("addi:rs1_k", rs1_out, 0);

    apply_stimulus(1, 0, 0, 0, 1, 3, 32'hDEADBEEF, 32'h003180B3, 32'h104);
    step("bypass");
    chk("bypass:rs1_k", rs1_out, 32'hDEADBEEF);
    chk("bypass:rs2_k", rs2_out, 32'hDEADBEEF);
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 32'h003180B3, 32'h108);
    step("rf_read");
    chk("rf_read:rs1_k", rs1_out, 32'hDEADBEEF);

    apply_stimulus(1, 0, 1, 6, 0, 0, 0, 32'h006083B3, 32'h10C);
    #1;
    chk("loaduse:stall_k", stall_out, 1);
    step("loaduse");
    chk("loaduse:valid_k", id_valid_out, 0);
    apply_stimulus(1, 0, 0, 6, 0, 0, 0, 32'h006083B3, 32'h10C);
    step("loaduse_release");
    chk("loaduse_release:valid_k", id_valid_out, 1);

    apply_stimulus(1, 1, 1, 6, 0, 0, 0, 32'h006083B3, 32'h110);
    #1;
    chk("flush_hz:stall_k", stall_out, 0);
    step("flush_hz");
    chk("flush_hz:valid_k", id_valid_out, 0);
    chk("flush_hz:regwrite_k", RegWrite_out, 0);
    chk("flush_hz:memw_k", mem_w_out, 0);

    apply_stimulus(1, 0, 0, 0, 1, 0, 32'h1234, 32'h00000133, 32'h114);
    step("x0_write");
    chk("x0_write:rs1_k", rs1_out, 0);
    apply_stimulus(1, 0, 1, 0, 0, 0, 0, 32'h00000133, 32'h118);
    #1;
    chk("x0_hz:stall_k", stall_out, 0);
    step("x0_hz");
    chk("x0_hz:rs1_k", rs1_out, 0);
    chk("x0_hz:valid_k", id_valid_out, 1);

    for (int n = 0; n < 300; n++) begin
      r_d   = 5'($urandom_range(0, 7));
      r_s1  = 5'($urandom_range(0, 7));
      r_s2  = 5'($urandom_range(0, 7));
      imm12 = 12'($urandom);
      case ($urandom_range(0, 3))
        0:       ins = {7'b0, r_s2, r_s1, 3'b000, r_d, 7'b0110011};
        1:       ins = {imm12, r_s1, 3'b000, r_d, 7'b0010011};
        2:       ins = {imm12, r_s1, 3'b010, r_d, 7'b0000011};
        default: ins = {imm12[11:5], r_s2, r_s1, 3'b010, imm12[4:0], 7'b0100011};
      endcase
      apply_stimulus($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
                     $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                     ins, $urandom & 32'hFFFF_FFFC);
      step("random");
    end

    apply_stimulus(1, 0, 0, 0, 1, 3, 32'hAA55AA55, 32'h003180B3, 32'h200);
    step("pre_reset_wr");
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 32'h003180B3, 32'h204);
    step("pre_reset_rd");
    chk("pre_reset_rd:valid_k", id_valid_out, 1);
    chk("pre_reset_rd:rs1_k", rs1_out, 32'hAA55AA55);
    rst = 1'b0;
    #2;
    check_zero_outputs("async_reset");
    foreach (mregs[i]) mregs[i] = 32'd0;
    @(posedge clk);
    #1;
    chk("in_reset:valid", id_valid_out, 0);
    rst = 1'b1;
    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 32'h003180B3, 32'h208);
    step("post_reset");
    chk("post_reset:valid_k", id_valid_out, 1);
    chk("post_reset:rs1_k", rs1_out, 0);
    chk("post_reset:rs2_k", rs2_out, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
